// File: rtl/sccb_pkg.sv
// Shared SCCB definitions: target FSM states, default camera address and
// bit-counter sizing. The SCCB master reuses CAM_ADDR from here.
package sccb_pkg;

  localparam logic [6:0] CAM_ADDR  = 7'h21;
  localparam int         BIT_CNT_W = 4;

  // Counter value at the 8th bit rise, and after it (read-side byte end).
  localparam logic [BIT_CNT_W-1:0] BIT_LAST = BIT_CNT_W'(7);
  localparam logic [BIT_CNT_W-1:0] BIT_DONE = BIT_CNT_W'(8);

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_DEV_ADDR,
    ST_ACK_DEV,
    ST_REG_ADDR,
    ST_ACK_REG,
    ST_WR_DATA,
    ST_ACK_WR,
    ST_RD_DATA,
    ST_RD_ACK,
    ST_IGNORE
  } sccb_state_t;

endpackage

// File: rtl/sccb_line_sync.sv
// Synchronizes SCL/SDA and produces registered SCL edge and START/STOP
// events. Events appear SYNC_STAGES+1 cycles after the pad change;
// o_sda is the SDA level aligned with those events.
module sccb_line_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_scl,
  input  logic i_sda,
  output logic o_sda,
  output logic o_scl_rise,
  output logic o_scl_fall,
  output logic o_start,
  output logic o_stop
);

  logic [SYNC_STAGES-1:0] r_scl_sync;
  logic [SYNC_STAGES-1:0] r_sda_sync;
  logic                   r_scl_prev;
  logic                   r_sda_prev;
  logic                   r_scl_rise;
  logic                   r_scl_fall;
  logic                   r_start;
  logic                   r_stop;
  logic                   w_scl;
  logic                   w_sda;

  assign w_scl = r_scl_sync[SYNC_STAGES-1];
  assign w_sda = r_sda_sync[SYNC_STAGES-1];

  // Synchronizer chains, previous-value registers and registered events.
  // START/STOP require SCL high on both samples, so an SDA change that
  // coincides with an SCL change is only ever a data edge.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_scl_sync <= '1;
      r_sda_sync <= '1;
      r_scl_prev <= 1'b1;
      r_sda_prev <= 1'b1;
      r_scl_rise <= 1'b0;
      r_scl_fall <= 1'b0;
      r_start    <= 1'b0;
      r_stop     <= 1'b0;
    end else begin
      r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], i_scl};
      r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], i_sda};
      r_scl_prev <= w_scl;
      r_sda_prev <= w_sda;
      r_scl_rise <= w_scl & ~r_scl_prev;
      r_scl_fall <= ~w_scl & r_scl_prev;
      r_start    <= w_scl & r_scl_prev & r_sda_prev & ~w_sda;
      r_stop     <= w_scl & r_scl_prev & ~r_sda_prev & w_sda;
    end
  end

  assign o_sda      = r_sda_prev;
  assign o_scl_rise = r_scl_rise;
  assign o_scl_fall = r_scl_fall;
  assign o_start    = r_start;
  assign o_stop     = r_stop;

endmodule

// File: rtl/sccb_target.sv
// SCCB/I2C target: decodes 3-phase writes and 2-phase reads, ACKs on
// open-drain SDA and exposes a register-port handshake.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// ST_IDLE     | bus free, waiting for START
// ST_DEV_ADDR | shifting in 7-bit address + R/W
// ST_ACK_DEV  | driving ACK for the address byte
// ST_REG_ADDR | shifting in the register pointer
// ST_ACK_REG  | driving ACK for the register pointer
// ST_WR_DATA  | shifting in a write data byte
// ST_ACK_WR   | driving ACK for write data, pointer increments at its end
// ST_RD_DATA  | shifting out read data MSB-first
// ST_RD_ACK   | sampling master ACK/NA after a read byte
// ST_IGNORE   | not addressed or read ended; wait for START/STOP
module sccb_target
  import sccb_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR    = CAM_ADDR,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_scl,
  inout  logic       io_sda,
  output logic [7:0] o_reg_addr,
  output logic [7:0] o_wr_data,
  output logic       o_wr_stb,
  input  logic [7:0] i_rd_data,
  output logic       o_rd_stb,
  output logic       o_busy
);

  sccb_state_t           r_state,   w_state_nxt;
  logic [7:0]            r_shift,   w_shift_nxt;
  logic [BIT_CNT_W-1:0]  r_cnt,     w_cnt_nxt;
  logic [7:0]            r_reg_addr, w_reg_addr_nxt;
  logic [7:0]            r_wr_data, w_wr_data_nxt;
  logic                  r_wr_stb,  w_wr_stb_nxt;
  logic                  r_rd_stb,  w_rd_stb_nxt;
  logic                  r_sda_low, w_sda_low_nxt;
  logic                  r_busy,    w_busy_nxt;
  logic                  r_rw,      w_rw_nxt;
  logic                  r_pend,    w_pend_nxt;

  logic       w_sda;
  logic       w_scl_rise;
  logic       w_scl_fall;
  logic       w_start;
  logic       w_stop;
  logic [7:0] w_shift_in;

  sccb_line_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_line_sync (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_scl      (i_scl),
    .i_sda      (io_sda),
    .o_sda      (w_sda),
    .o_scl_rise (w_scl_rise),
    .o_scl_fall (w_scl_fall),
    .o_start    (w_start),
    .o_stop     (w_stop)
  );

  assign w_shift_in = {r_shift[6:0], w_sda};

  // State and datapath registers; reset releases SDA on the first edge.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state    <= ST_IDLE;
      r_shift    <= 8'h00;
      r_cnt      <= '0;
      r_reg_addr <= 8'h00;
      r_wr_data  <= 8'h00;
      r_wr_stb   <= 1'b0;
      r_rd_stb   <= 1'b0;
      r_sda_low  <= 1'b0;
      r_busy     <= 1'b0;
      r_rw       <= 1'b0;
      r_pend     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_shift    <= w_shift_nxt;
      r_cnt      <= w_cnt_nxt;
      r_reg_addr <= w_reg_addr_nxt;
      r_wr_data  <= w_wr_data_nxt;
      r_wr_stb   <= w_wr_stb_nxt;
      r_rd_stb   <= w_rd_stb_nxt;
      r_sda_low  <= w_sda_low_nxt;
      r_busy     <= w_busy_nxt;
      r_rw       <= w_rw_nxt;
      r_pend     <= w_pend_nxt;
    end
  end

  // Next-state and datapath decode. STOP/START override every state.
  // In the ACK states the first SCL fall starts driving ACK and the
  // second fall (end of the 9th clock) releases it.
  always_comb begin
    w_state_nxt    = r_state;
    w_shift_nxt    = r_shift;
    w_cnt_nxt      = r_cnt;
    w_reg_addr_nxt = r_reg_addr;
    w_wr_data_nxt  = r_wr_data;
    w_wr_stb_nxt   = 1'b0;
    w_rd_stb_nxt   = 1'b0;
    w_sda_low_nxt  = r_sda_low;
    w_busy_nxt     = r_busy;
    w_rw_nxt       = r_rw;
    w_pend_nxt     = r_pend;

    if (w_stop) begin
      w_state_nxt   = ST_IDLE;
      w_sda_low_nxt = 1'b0;
      w_busy_nxt    = 1'b0;
      w_pend_nxt    = 1'b0;
    end else if (w_start) begin
      w_state_nxt   = ST_DEV_ADDR;
      w_cnt_nxt     = '0;
      w_sda_low_nxt = 1'b0;
      w_pend_nxt    = 1'b0;
    end else begin
      case (r_state)
        ST_DEV_ADDR: begin
          if (w_scl_rise) begin
            w_shift_nxt = w_shift_in;
            w_cnt_nxt   = r_cnt + 1'b1;
            if (r_cnt == BIT_LAST) begin
              if (w_shift_in[7:1] == DEV_ADDR) begin
                w_state_nxt = ST_ACK_DEV;
                w_busy_nxt  = 1'b1;
                w_rw_nxt    = w_sda;
              end else begin
                w_state_nxt = ST_IGNORE;
              end
            end
          end
        end
        ST_ACK_DEV: begin
          if (w_scl_fall) begin
            if (!r_sda_low) begin
              w_sda_low_nxt = 1'b1;
            end else begin
              w_cnt_nxt = '0;
              if (r_rw) begin
                w_shift_nxt   = i_rd_data;
                w_rd_stb_nxt  = 1'b1;
                w_sda_low_nxt = ~i_rd_data[7];
                w_state_nxt   = ST_RD_DATA;
              end else begin
                w_sda_low_nxt = 1'b0;
                w_state_nxt   = ST_REG_ADDR;
              end
            end
          end
        end
        ST_REG_ADDR: begin
          if (w_scl_rise) begin
            w_shift_nxt = w_shift_in;
            w_cnt_nxt   = r_cnt + 1'b1;
            if (r_cnt == BIT_LAST) begin
              w_reg_addr_nxt = w_shift_in;
              w_state_nxt    = ST_ACK_REG;
            end
          end
        end
        ST_ACK_REG: begin
          if (w_scl_fall) begin
            if (!r_sda_low) begin
              w_sda_low_nxt = 1'b1;
            end else begin
              w_sda_low_nxt = 1'b0;
              w_cnt_nxt     = '0;
              w_state_nxt   = ST_WR_DATA;
            end
          end
        end
        ST_WR_DATA: begin
          if (w_scl_rise) begin
            w_shift_nxt = w_shift_in;
            w_cnt_nxt   = r_cnt + 1'b1;
            if (r_cnt == BIT_LAST) begin
              w_wr_data_nxt = w_shift_in;
              w_wr_stb_nxt  = 1'b1;
              w_state_nxt   = ST_ACK_WR;
            end
          end
        end
        ST_ACK_WR: begin
          if (w_scl_fall) begin
            if (!r_sda_low) begin
              w_sda_low_nxt = 1'b1;
            end else begin
              w_sda_low_nxt  = 1'b0;
              w_cnt_nxt      = '0;
              w_reg_addr_nxt = r_reg_addr + 8'd1;
              w_state_nxt    = ST_WR_DATA;
            end
          end
        end
        // Shift on the rise so the next bit to present sits in r_shift[7].
        ST_RD_DATA: begin
          if (w_scl_rise) begin
            w_shift_nxt = w_shift_in;
            w_cnt_nxt   = r_cnt + 1'b1;
          end else if (w_scl_fall) begin
            if (r_cnt == BIT_DONE) begin
              w_sda_low_nxt = 1'b0;
              w_pend_nxt    = 1'b0;
              w_state_nxt   = ST_RD_ACK;
            end else begin
              w_sda_low_nxt = ~r_shift[7];
            end
          end
        end
        ST_RD_ACK: begin
          if (w_scl_rise && !r_pend) begin
            if (!w_sda) begin
              w_reg_addr_nxt = r_reg_addr + 8'd1;
              w_pend_nxt     = 1'b1;
            end else begin
              w_state_nxt = ST_IGNORE;
            end
          end else if (w_scl_fall && r_pend) begin
            w_shift_nxt   = i_rd_data;
            w_rd_stb_nxt  = 1'b1;
            w_sda_low_nxt = ~i_rd_data[7];
            w_cnt_nxt     = '0;
            w_pend_nxt    = 1'b0;
            w_state_nxt   = ST_RD_DATA;
          end
        end
        ST_IDLE, ST_IGNORE: begin
        end
        default: begin
          w_state_nxt   = ST_IDLE;
          w_sda_low_nxt = 1'b0;
        end
      endcase
    end
  end

  assign io_sda     = r_sda_low ? 1'b0 : 1'bz;
  assign o_reg_addr = r_reg_addr;
  assign o_wr_data  = r_wr_data;
  assign o_wr_stb   = r_wr_stb;
  assign o_rd_stb   = r_rd_stb;
  assign o_busy     = r_busy;

endmodule
